// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: synchronises din_in, decodes pulse widths into bits,
// assembles 24-bit pixels and reports frame ends and protocol errors.
module ws2812_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PIX_MAX     = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        din_in,
    input  logic [7:0]  thr_in,
    input  logic [15:0] rst_cnt_in,
    output logic        pix_valid_out,
    output logic [23:0] pix_data_out,
    output logic [5:0]  pix_addr_out,
    output logic        frame_done_out,
    output logic        err_out
);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [5:0] LAST_IDX = 6'(PIX_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_s;
    logic                   d_q;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= '0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_in};
            d_q    <= d_s;
        end
    end

    assign d_s  = sync_q[SYNC_STAGES-1];
    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;

    state_t      state_q, state_d;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [7:0]  high_cnt_q, high_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [5:0]  pix_idx_q, pix_idx_d;
    logic        wrapped_q, wrapped_d;
    logic        got_bit_q, got_bit_d;
    logic        pix_valid_d;
    logic [23:0] pix_data_d;
    logic [5:0]  pix_addr_d;
    logic        frame_done_d;
    logic        err_d;

    logic [15:0] low_inc;
    logic [7:0]  high_inc;
    logic [23:0] shift_nxt;

    assign low_inc   = (low_cnt_q == 16'hFFFF) ? low_cnt_q : low_cnt_q + 16'd1;
    assign high_inc  = (high_cnt_q == 8'hFF) ? high_cnt_q : high_cnt_q + 8'd1;
    assign shift_nxt = {shift_q[22:0], (high_cnt_q > thr_in)};

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        low_cnt_d    = low_cnt_q;
        high_cnt_d   = high_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pix_idx_d    = pix_idx_q;
        wrapped_d    = wrapped_q;
        got_bit_d    = got_bit_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_out;
        pix_addr_d   = pix_addr_out;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (d_s) begin
                    low_cnt_d = 16'd0;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc >= rst_cnt_in) state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (rise) begin
                    high_cnt_d = 8'd1;
                    state_d    = S_HIGH;
                end
            end

            S_HIGH: begin
                if (fall) begin
                    got_bit_d = 1'b1;
                    low_cnt_d = 16'd1;
                    state_d   = S_LOW;
                    if (bit_cnt_q == 5'd23) begin
                        // Last bit of a pixel: present it on the next cycle and move to the next index.
                        pix_valid_d = 1'b1;
                        pix_data_d  = shift_nxt;
                        pix_addr_d  = pix_idx_q;
                        err_d       = wrapped_q;
                        wrapped_d   = (pix_idx_q == LAST_IDX);
                        pix_idx_d   = (pix_idx_q == LAST_IDX) ? 6'd0 : pix_idx_q + 6'd1;
                        bit_cnt_d   = 5'd0;
                        shift_d     = 24'h000000;
                    end else begin
                        shift_d   = shift_nxt;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (high_inc == 8'hFF) begin
                    high_cnt_d = high_inc;
                    err_d      = 1'b1;
                    state_d    = S_SYNC;
                    low_cnt_d  = 16'd0;
                    bit_cnt_d  = 5'd0;
                    shift_d    = 24'h000000;
                    pix_idx_d  = 6'd0;
                    wrapped_d  = 1'b0;
                    got_bit_d  = 1'b0;
                end else begin
                    high_cnt_d = high_inc;
                end
            end

            S_LOW: begin
                if (rise) begin
                    high_cnt_d = 8'd1;
                    state_d    = S_HIGH;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc >= rst_cnt_in) begin
                        // Reset code: close the frame, flagging any partial pixel.
                        state_d      = S_IDLE;
                        frame_done_d = got_bit_q;
                        err_d        = (bit_cnt_q != 5'd0);
                        bit_cnt_d    = 5'd0;
                        shift_d      = 24'h000000;
                        pix_idx_d    = 6'd0;
                        wrapped_d    = 1'b0;
                        got_bit_d    = 1'b0;
                    end
                end
            end

            default: state_d = S_SYNC;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= S_SYNC;
            low_cnt_q      <= 16'd0;
            high_cnt_q     <= 8'd0;
            bit_cnt_q      <= 5'd0;
            shift_q        <= 24'h000000;
            pix_idx_q      <= 6'd0;
            wrapped_q      <= 1'b0;
            got_bit_q      <= 1'b0;
            pix_valid_out  <= 1'b0;
            pix_data_out   <= 24'h000000;
            pix_addr_out   <= 6'd0;
            frame_done_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            state_q        <= state_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            pix_idx_q      <= pix_idx_d;
            wrapped_q      <= wrapped_d;
            got_bit_q      <= got_bit_d;
            pix_valid_out  <= pix_valid_d;
            pix_data_out   <= pix_data_d;
            pix_addr_out   <= pix_addr_d;
            frame_done_out <= frame_done_d;
            err_out        <= err_d;
        end
    end

endmodule
